apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_master_if.sv | 37 +++
 rtl/apb_cmd_fifo.sv | 65 ++++++
 rtl/apb_master.sv | 159 +++++++++++++++
 tb/tb_apb_master.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Types shared by the APB master slice: the FSM state encoding and the queued command.
// APB_DW is the data/address width that the command struct is built with.
package apb_pkg;

   localparam int APB_DW = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   typedef struct packed {
      logic              write;
      logic [APB_DW-1:0] addr;
      logic [APB_DW-1:0] wdata;
   } apb_cmd_t;

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB bus signals of apb_master.
// The master modport is the DUT view; the slave modport is the environment view.
interface apb_master_if #(
   parameter int data_size = 8
);

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_write;
   logic [data_size-1:0] cmd_addr;
   logic [data_size-1:0] cmd_wdata;
   logic                 rsp_valid;
   logic                 rsp_write;
   logic [data_size-1:0] rsp_rdata;
   logic                 rsp_timeout;
   logic                 psel;
   logic                 penable;
   logic                 pwrite;
   logic [data_size-1:0] paddr;
   logic [data_size-1:0] pwdata;
   logic [data_size-1:0] prdata;
   logic                 pready;
   logic                 busy;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
      output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
      output psel, penable, pwrite, paddr, pwdata, busy
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
      input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
      input  psel, penable, pwrite, paddr, pwdata, busy
   );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Command queue: power-of-two depth, wrap-around pointers, occupancy 0..DEPTH.
// Pushes while full and pops while empty are ignored; push+pop together keep the count.
module apb_cmd_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic                   pclk,
   input  logic                   presetn,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             push_en, pop_en;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;

   // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; an empty count already hides stale entries.
   always_ff @(posedge pclk) begin
      if (push_en) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/apb_master.sv
// APB master: queued commands are issued as SETUP/ACCESS transfers with registered APB outputs.
// Optional ACCESS wait limit: define APB_MASTER_TIMEOUT_EN.
module apb_master
   import apb_pkg::*;
#(
   parameter int data_size      = APB_DW,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic          pclk,
   input logic          presetn,
   apb_master_if.master bus
);

   apb_state_e           state_q, state_d;
   logic                 psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic                 pwrite_q, pwrite_d;
   logic [data_size-1:0] paddr_q, paddr_d;
   logic [data_size-1:0] pwdata_q, pwdata_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_write_q, rsp_write_d;
   logic [data_size-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_timeout_q, rsp_timeout_d;

   apb_cmd_t                    push_cmd, head_cmd;
   logic                        pop, launch, full, empty, timeout_hit;
   logic [$clog2(FIFO_DEPTH):0] count;

   assign push_cmd = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

   apb_cmd_fifo #(
      .WIDTH ($bits(apb_cmd_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .pclk    (pclk),
      .presetn (presetn),
      .push    (bus.cmd_valid),
      .wdata   (push_cmd),
      .pop     (pop),
      .rdata   (head_cmd),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wait_cnt_q, wait_cnt_d;

   // SETUP always precedes ACCESS, so clearing there clears on ACCESS entry.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_q == SETUP)                       wait_cnt_d = '0;
      else if (state_q == ACCESS && !bus.pready) wait_cnt_d = wait_cnt_q + TW'(1);
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) wait_cnt_q <= '0;
      else          wait_cnt_q <= wait_cnt_d;
   end

   assign timeout_hit = (state_q == ACCESS) && !bus.pready &&
                        (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_write_d   = rsp_write_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_timeout_d = 1'b0;
      launch        = 1'b0;
      case (state_q)
         IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            launch    = !empty;
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (bus.pready || timeout_hit) begin
               rsp_valid_d   = 1'b1;
               rsp_write_d   = pwrite_q;
               rsp_timeout_d = timeout_hit;
               if (bus.pready && !pwrite_q) rsp_rdata_d = bus.prdata;
               // Back-to-back: a waiting command goes straight to SETUP.
               if (!empty) begin
                  launch = 1'b1;
               end else begin
                  state_d   = IDLE;
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (launch) begin
         state_d   = SETUP;
         psel_d    = 1'b1;
         penable_d = 1'b0;
         pwrite_d  = head_cmd.write;
         paddr_d   = head_cmd.addr;
         pwdata_d  = head_cmd.wdata;
      end
   end

   assign pop = launch;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q       <= IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_write_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_write_q   <= rsp_write_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign bus.psel        = psel_q;
   assign bus.penable     = penable_q;
   assign bus.pwrite      = pwrite_q;
   assign bus.paddr       = paddr_q;
   assign bus.pwdata      = pwdata_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_write   = rsp_write_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.cmd_ready   = !full;
   assign bus.busy        = (state_q != IDLE) || (count != '0);

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: stimulus pushes expected transfers/responses,
// a negedge monitor pops and compares them whenever the DUT shows SETUP or rsp_valid.
module tb_apb_master;
   import apb_pkg::*;

   typedef struct {
      logic       write;
      logic [7:0] rdata;
      logic       timeout;
   } rsp_t;

   logic pclk = 1'b0;
   logic presetn;

   apb_master_if #(.data_size(8)) bus ();

   apb_master #(
      .data_size      (8),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus)
   );

   always #5 pclk = ~pclk;

   rsp_t       exp_rsp[$];
   apb_cmd_t   exp_xfer[$];
   rsp_t       mon_r;
   apb_cmd_t   mon_x;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_rdata = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // Offer one command until accepted; rd is the prdata the slave will return for a read.
   task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] rd, input logic to);
      bit   done;
      rsp_t r;
      done          = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      for (int i = 0; i < 50 && !done; i++) begin
         if (bus.cmd_ready) done = 1'b1;
         tick();
      end
      bus.cmd_valid = 1'b0;
      check("cmd_accepted", {31'd0, done}, 32'd1);
      if (done) begin
         exp_xfer.push_back('{write: w, addr: a, wdata: d});
         if (!w && !to) model_rdata = rd;
         r.write   = w;
         r.rdata   = model_rdata;
         r.timeout = to;
         exp_rsp.push_back(r);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && bus.busy; i++) tick();
      check("wait_idle_busy", {31'd0, bus.busy}, 32'd0);
   endtask

   always @(negedge pclk) begin
      if (presetn) begin
         if (bus.rsp_valid) begin
            if (exp_rsp.size() == 0) begin
               check("rsp_unexpected_valid", {31'd0, bus.rsp_valid}, 32'd0);
            end else begin
               mon_r = exp_rsp.pop_front();
               check("rsp_write",   {31'd0, bus.rsp_write},   {31'd0, mon_r.write});
               check("rsp_rdata",   {24'd0, bus.rsp_rdata},   {24'd0, mon_r.rdata});
               check("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, mon_r.timeout});
            end
         end
         if (bus.psel && !bus.penable) begin
            if (exp_xfer.size() == 0) begin
               check("setup_unexpected_psel", {31'd0, bus.psel}, 32'd0);
            end else begin
               mon_x = exp_xfer.pop_front();
               check("setup_pwrite", {31'd0, bus.pwrite}, {31'd0, mon_x.write});
               check("setup_paddr",  {24'd0, bus.paddr},  {24'd0, mon_x.addr});
               check("setup_pwdata", {24'd0, bus.pwdata}, {24'd0, mon_x.wdata});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      presetn       = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 8'h00;
      bus.cmd_wdata = 8'h00;
      bus.prdata    = 8'h00;
      bus.pready    = 1'b1;
      #1 presetn = 1'b0;
      #2;
      check("rst_psel",        {31'd0, bus.psel},        32'd0);
      check("rst_penable",     {31'd0, bus.penable},     32'd0);
      check("rst_pwrite",      {31'd0, bus.pwrite},      32'd0);
      check("rst_paddr",       {24'd0, bus.paddr},       32'd0);
      check("rst_pwdata",      {24'd0, bus.pwdata},      32'd0);
      check("rst_rsp_valid",   {31'd0, bus.rsp_valid},   32'd0);
      check("rst_rsp_rdata",   {24'd0, bus.rsp_rdata},   32'd0);
      check("rst_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
      check("rst_busy",        {31'd0, bus.busy},        32'd0);
      check("rst_cmd_ready",   {31'd0, bus.cmd_ready},   32'd1);
      @(negedge pclk);
      @(negedge pclk);
      presetn = 1'b1;
      tick();

      // Single write with pready high: exact SETUP/ACCESS/response latency.
      bus.pready = 1'b1;
      issue(1'b1, 8'h02, 8'hA5, 8'h00, 1'b0);
      check("wr_n_psel",      {31'd0, bus.psel},      32'd0);
      tick();
      check("wr_n1_psel",     {31'd0, bus.psel},      32'd1);
      check("wr_n1_penable",  {31'd0, bus.penable},   32'd0);
      tick();
      check("wr_n2_psel",     {31'd0, bus.psel},      32'd1);
      check("wr_n2_penable",  {31'd0, bus.penable},   32'd1);
      check("wr_n2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
      check("wr_n3_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("wr_n3_psel",     {31'd0, bus.psel},      32'd0);
      tick();
      check("wr_n4_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      wait_idle();

      // Read captures prdata; a following write must not disturb rsp_rdata.
      bus.prdata = 8'h0C;
      issue(1'b0, 8'h03, 8'h00, 8'h0C, 1'b0);
      wait_idle();
      tick();
      check("rd_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h0C);
      bus.prdata = 8'hFF;
      issue(1'b1, 8'h04, 8'h5A, 8'h00, 1'b0);
      wait_idle();
      tick();
      check("wr_keeps_rdata", {24'd0, bus.rsp_rdata}, 32'h0C);

      // Five wait states: ACCESS lasts six cycles with stable bus outputs.
      bus.pready = 1'b0;
      issue(1'b1, 8'h10, 8'h33, 8'h00, 1'b0);
      tick();
      tick();
      for (int i = 0; i < 6; i++) begin
         check("wait_psel",      {31'd0, bus.psel},      32'd1);
         check("wait_penable",   {31'd0, bus.penable},   32'd1);
         check("wait_pwrite",    {31'd0, bus.pwrite},    32'd1);
         check("wait_paddr",     {24'd0, bus.paddr},     32'h10);
         check("wait_pwdata",    {24'd0, bus.pwdata},    32'h33);
         check("wait_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
         if (i == 5) bus.pready = 1'b1;
         tick();
      end
      check("wait_done_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("wait_done_psel",      {31'd0, bus.psel},      32'd0);
      wait_idle();

      // Five back-to-back commands with pready low fill the queue, then drain with no IDLE gap.
      bus.pready = 1'b0;
      bus.prdata = 8'h77;
      issue(1'b1, 8'h40, 8'h01, 8'h00, 1'b0);
      issue(1'b1, 8'h41, 8'h02, 8'h00, 1'b0);
      issue(1'b0, 8'h42, 8'h00, 8'h77, 1'b0);
      issue(1'b1, 8'h43, 8'h04, 8'h00, 1'b0);
      issue(1'b1, 8'h44, 8'h05, 8'h00, 1'b0);
      check("full_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      bus.pready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         check("b2b_psel_held", {31'd0, bus.psel}, 32'd1);
         tick();
      end
      check("b2b_last_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("b2b_end_psel",       {31'd0, bus.psel},      32'd0);
      wait_idle();
      tick();
      check("b2b_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h77);

`ifdef APB_MASTER_TIMEOUT_EN
      // pready stuck low: abort after sixteen wait cycles, rdata unchanged.
      bus.pready = 1'b0;
      bus.prdata = 8'h99;
      issue(1'b0, 8'h20, 8'h00, 8'h99, 1'b1);
      tick();
      tick();
      for (int i = 0; i < 15; i++) tick();
      check("to_early_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("to_early_psel",      {31'd0, bus.psel},      32'd1);
      tick();
      check("to_rsp_valid",   {31'd0, bus.rsp_valid},   32'd1);
      check("to_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd1);
      check("to_psel_idle",   {31'd0, bus.psel},        32'd0);
      wait_idle();
      bus.pready = 1'b1;
`endif

      // Reset mid-ACCESS abandons the transfer and the queued commands.
      bus.pready = 1'b0;
      issue(1'b1, 8'h50, 8'hE1, 8'h00, 1'b0);
      issue(1'b1, 8'h51, 8'hE2, 8'h00, 1'b0);
      issue(1'b1, 8'h52, 8'hE3, 8'h00, 1'b0);
      check("pre_rst_penable", {31'd0, bus.penable}, 32'd1);
      #2 presetn = 1'b0;
      #1;
      check("arst_psel",      {31'd0, bus.psel},      32'd0);
      check("arst_penable",   {31'd0, bus.penable},   32'd0);
      check("arst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check("arst_busy",      {31'd0, bus.busy},      32'd0);
      check("arst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      exp_rsp.delete();
      exp_xfer.delete();
      model_rdata = 8'h00;
      bus.pready  = 1'b1;
      @(negedge pclk);
      @(negedge pclk);
      presetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_psel", {31'd0, bus.psel}, 32'd0);
         check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
      end

      issue(1'b1, 8'h30, 8'h3C, 8'h00, 1'b0);
      wait_idle();
      tick();
      check("post_rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h00);

      tick();
      tick();
      check("rsp_queue_drained",  exp_rsp.size(),  32'd0);
      check("xfer_queue_drained", exp_xfer.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
